multiplier_controller_taint_track_1bit: RTL and testbench

- Shift-add control FSM that drives the 1-bit taint-tracking sequential multiplier datapath.
- Generates mdld/mrld/rsclear/rsload/rsshr and their taint bits. Reads the datapath's multiplierReg and multiplierReg_t.
- Signals completion with done/done_t.
- Control-flow taint: a strobe decided by tainted data carries taint, even when the strobe is deasserted.

---
 rtl/multiplier_controller_taint_track_1bit.sv | 134 +++++++++++++
 tb/tb_multiplier_controller_taint_track_1bit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_controller_taint_track_1bit.sv
// rtl/multiplier_controller_taint_track_1bit.sv - shift-add multiplier control FSM with 1-bit taint tracking
//
// Drives the taint-tracking sequential multiplier datapath one multiplier bit
// at a time: LOAD once, then a TEST/SHIFT pair per bit, then a one-cycle DONE.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start, start_t                 begin a multiply (sampled in IDLE) and its taint
//   multiplierReg, multiplierReg_t registered multiplier from the datapath and its taint
//   mdld, mrld, rsclear            load multiplicand / multiplier, clear result (LOAD)
//   rsload                         add multiplicand into result (TEST, when bit set)
//   rsshr                          advance to the next bit (SHIFT)
//   *_t                            taint of each strobe, valid in every state
//   busy                           high whenever the FSM is not idle
//   done, done_t                   one-cycle completion pulse and its taint

module multiplier_controller_taint_track_1bit #(
    parameter int WIDTH = 1024,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic             multiplierReg_t,
    output logic             mdld,
    output logic             mrld,
    output logic             rsclear,
    output logic             rsload,
    output logic             rsshr,
    output logic             mdld_t,
    output logic             mrld_t,
    output logic             rsclear_t,
    output logic             rsload_t,
    output logic             rsshr_t,
    output logic             busy,
    output logic             done,
    output logic             done_t
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TEST,
        S_SHIFT,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ctrl_t_q, ctrl_t_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ctrl_t_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_t_q <= ctrl_t_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_t_d = ctrl_t_q;
        mdld     = 1'b0;
        mrld     = 1'b0;
        rsclear  = 1'b0;
        rsload   = 1'b0;
        rsshr    = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    cnt_d    = '0;
                    ctrl_t_d = start_t;
                end else begin
                    // Declining to start on a tainted start is itself a tainted decision.
                    ctrl_t_d = ctrl_t_q | start_t;
                end
            end
            S_LOAD: begin
                mdld    = 1'b1;
                mrld    = 1'b1;
                rsclear = 1'b1;
                state_d = S_TEST;
            end
            S_TEST: begin
                // Mealy on the registered multiplier: the branch is data-dependent.
                rsload   = multiplierReg[cnt_q];
                ctrl_t_d = ctrl_t_q | multiplierReg_t;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                rsshr = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_TEST;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control-flow taint: every strobe carries the sticky operation taint whether
    // or not it is asserted. rsload also folds in the current-cycle multiplier
    // taint, since ctrl_t only absorbs it at the end of the TEST cycle.
    always_comb begin
        mdld_t    = ctrl_t_q;
        mrld_t    = ctrl_t_q;
        rsclear_t = ctrl_t_q;
        rsshr_t   = ctrl_t_q;
        done_t    = ctrl_t_q;
        rsload_t  = ctrl_t_q | ((state_q == S_TEST) & multiplierReg_t);
    end

endmodule

// File: tb/tb_multiplier_controller_taint_track_1bit.sv
// tb/tb_multiplier_controller_taint_track_1bit.sv - self-checking bench for multiplier_controller_taint_track_1bit
module tb_multiplier_controller_taint_track_1bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, start_t;
    logic [W-1:0] mreg;
    logic         mreg_t;
    logic         mdld, mrld, rsclear, rsload, rsshr;
    logic         mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t;
    logic         busy, done, done_t;

    multiplier_controller_taint_track_1bit #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_t         (start_t),
        .multiplierReg   (mreg),
        .multiplierReg_t (mreg_t),
        .mdld            (mdld),
        .mrld            (mrld),
        .rsclear         (rsclear),
        .rsload          (rsload),
        .rsshr           (rsshr),
        .mdld_t          (mdld_t),
        .mrld_t          (mrld_t),
        .rsclear_t       (rsclear_t),
        .rsload_t        (rsload_t),
        .rsshr_t         (rsshr_t),
        .busy            (busy),
        .done            (done),
        .done_t          (done_t)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: ph is the cycle offset since the start was accepted
    // (-1 when idle); mt is the accumulated operation taint.
    int   ph = -1;
    logic mt = 1'b0;
    // Behavioural datapath driven by the observed strobes.
    int   acc = 0, shc = 0, mcand = 0, exp_prod = 0;
    bit   prod_en = 0;

    typedef struct {
        logic        start;
        logic [12:0] exp;
    } vec_t;
    vec_t tab[12];

    function automatic logic [12:0] outs();
        return {busy, done, mdld, mrld, rsclear, rsload, rsshr,
                done_t, mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t};
    endfunction

    function logic [12:0] model_out();
        logic [12:0] e;
        e = '0;
        e[5:0] = {6{mt}};
        if (ph == 1) begin
            e[12:6] = 7'b1011100;
        end else if (ph >= 2 && ph <= 2 * W + 1) begin
            e[12] = 1'b1;
            if (ph % 2 == 0) begin
                e[7] = mreg[(ph - 2) / 2];
                e[1] = mt | mreg_t;
            end else begin
                e[6] = 1'b1;
            end
        end else if (ph == 2 * W + 2) begin
            e[12] = 1'b1;
            e[11] = 1'b1;
        end
        return e;
    endfunction

    task automatic model_advance();
        if (ph < 0) begin
            if (start) begin
                ph = 1;
                mt = start_t;
            end else begin
                mt = mt | start_t;
            end
        end else if (ph == 2 * W + 2) begin
            ph = -1;
        end else begin
            if (ph >= 2 && ph % 2 == 0) mt = mt | mreg_t;
            ph = ph + 1;
        end
    endtask

    task automatic model_reset();
        ph  = -1;
        mt  = 1'b0;
        acc = 0;
        shc = 0;
    endtask

    task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle(input string nm, input bit use_tab, input logic [12:0] tab_exp);
        logic [12:0] got;
        #3;
        got = outs();
        chk(nm, got, model_out());
        if (use_tab) chk({nm, "_tab"}, got, tab_exp);
        if (rsload && rsshr) begin
            checks++;
            errors++;
            $display("FAIL %s_overlap: got rsload=1 rsshr=1 expected never both", nm);
        end
        if (prod_en && ph == 2 * W + 2) chk_int({nm, "_product"}, acc, exp_prod);
        if (mdld) begin
            acc = 0;
            shc = 0;
        end
        if (rsload) acc = acc + (mcand << shc);
        if (rsshr) shc = shc + 1;
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] mr, input int md,
                          input logic st_t, input logic mr_t, input int prod);
        mreg     = mr;
        mcand    = md;
        exp_prod = prod;
        prod_en  = 1;
        mreg_t   = mr_t;
        start    = 1'b1;
        start_t  = st_t;
        cycle(nm, 0, '0);
        start   = 1'b0;
        start_t = 1'b0;
        for (int i = 1; i <= 2 * W + 3; i++) cycle(nm, 0, '0);
        prod_en = 0;
    endtask

    initial begin
        tab[0]  = '{1'b1, 13'b0_0_000_00_000000};
        tab[1]  = '{1'b0, 13'b1_0_111_00_000000};
        tab[2]  = '{1'b0, 13'b1_0_000_10_000000};
        tab[3]  = '{1'b0, 13'b1_0_000_01_000000};
        tab[4]  = '{1'b0, 13'b1_0_000_10_000000};
        tab[5]  = '{1'b0, 13'b1_0_000_01_000000};
        tab[6]  = '{1'b0, 13'b1_0_000_00_000000};
        tab[7]  = '{1'b0, 13'b1_0_000_01_000000};
        tab[8]  = '{1'b0, 13'b1_0_000_10_000000};
        tab[9]  = '{1'b0, 13'b1_0_000_01_000000};
        tab[10] = '{1'b0, 13'b1_1_000_00_000000};
        tab[11] = '{1'b0, 13'b0_0_000_00_000000};

        rst_n   = 1'b0;
        start   = 1'b0;
        start_t = 1'b0;
        mreg    = '0;
        mreg_t  = 1'b0;
        @(posedge clk);
        #1;
        cycle("reset", 1, 13'b0);
        rst_n = 1'b1;
        cycle("idle", 0, '0);

        // 4'b1011 x 5 via the table.
        mreg     = 4'b1011;
        mcand    = 5;
        exp_prod = 55;
        prod_en  = 1;
        for (int i = 0; i < 12; i++) begin
            start = tab[i].start;
            cycle($sformatf("t1011_c%0d", i), 1, tab[i].exp);
        end
        prod_en = 0;

        run_op("zero", 4'b0000, 15, 1'b0, 1'b0, 0);
        run_op("st_taint", 4'b0110, 7, 1'b1, 1'b0, 42);
        checks++;
        if (done_t !== 1'b1 || mdld_t !== 1'b1) begin
            errors++;
            $display("FAIL idle_taint_sticky: got done_t=%b mdld_t=%b expected 1", done_t, mdld_t);
        end
        run_op("clear_taint", 4'b0001, 9, 1'b0, 1'b0, 9);
        run_op("mr_taint", 4'b1111, 2, 1'b0, 1'b1, 30);

        // Asynchronous reset during the third TEST cycle.
        mreg   = 4'b0111;
        mcand  = 6;
        mreg_t = 1'b1;
        start  = 1'b1;
        cycle("rst_pre", 0, '0);
        start = 1'b0;
        for (int i = 0; i < 20 && ph != 6; i++) cycle("rst_pre", 0, '0);
        chk_int("rst_reached_test3", ph, 6);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async", outs(), 13'b0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mreg_t = 1'b0;
        model_reset();
        run_op("after_rst", 4'b0011, 3, 1'b0, 1'b0, 9);

        // start held high for 25 cycles.
        mreg  = 4'b0101;
        mcand = 1;
        start = 1'b1;
        for (int i = 0; i < 25; i++) begin
            #2;
            chk_int($sformatf("held_done_c%0d", i), int'(done), (i == 10 || i == 21) ? 1 : 0);
            chk_int($sformatf("held_busy_c%0d", i), int'(busy), (i == 0 || i == 11 || i == 22) ? 0 : 1);
            chk_int($sformatf("held_load_c%0d", i), int'(mdld), (i == 1 || i == 12 || i == 23) ? 1 : 0);
            #(-2 + 2);
            cycle($sformatf("held_c%0d", i), 0, '0);
        end
        start = 1'b0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            start_t = ($urandom_range(0, 7) == 0);
            mreg_t  = ($urandom_range(0, 9) == 0);
            mreg    = W'($urandom);
            cycle("rand", 0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
